// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Instruction-memory and decoder handshake bundle for the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  pc_mux_sel;
    logic        br_taken;
    logic [31:0] rs_value;
    logic        is_illegal;
    logic        halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        output instruction, instr_pc, instr_valid,
        input  instr_ready, pc_mux_sel, br_taken, rs_value, is_illegal,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        input  instruction, instr_pc, instr_valid,
        output instr_ready, pc_mux_sel, br_taken, rs_value, is_illegal,
        input  halted
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner; fetches words, presents them to decode, one PC+4 prefetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    instr_fetch_unit_if.master   bus
);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t      r_state,       w_state;
    logic [31:0] r_pc,          w_pc;
    logic        r_outstanding, w_outstanding;
    logic        r_kill,        w_kill;
    logic        r_skid_valid,  w_skid_valid;
    logic [31:0] r_skid_data,   w_skid_data;
    logic [31:0] r_instruction, w_instruction;
    logic [31:0] r_instr_pc,    w_instr_pc;
    logic        r_instr_valid, w_instr_valid;
    logic        r_halted,      w_halted;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic        w_handoff;
    logic        w_rsp;
    logic        w_prefetch;
    logic        w_skid_avail;
    logic        w_in_flight;
    logic [31:0] w_skid_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RESET;
            r_pc          <= RESET_PC;
            r_outstanding <= 1'b0;
            r_kill        <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_data   <= 32'h0;
            r_instruction <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_outstanding <= w_outstanding;
            r_kill        <= w_kill;
            r_skid_valid  <= w_skid_valid;
            r_skid_data   <= w_skid_data;
            r_instruction <= w_instruction;
            r_instr_pc    <= w_instr_pc;
            r_instr_valid <= w_instr_valid;
            r_halted      <= w_halted;
        end
    end

    // Redirect target of the word currently presented to decode
    always_comb begin
        w_pc4 = r_instr_pc + 32'd4;
        case (bus.pc_mux_sel)
            2'b00:   w_next_pc = bus.rs_value & ~32'h3;
            2'b01:   w_next_pc = bus.br_taken
                               ? w_pc4 + {{14{r_instruction[15]}}, r_instruction[15:0], 2'b00}
                               : w_pc4;
            2'b10:   w_next_pc = (w_pc4 & 32'hF000_0000) | {4'b0000, r_instruction[25:0], 2'b00};
            default: w_next_pc = w_pc4;
        endcase
    end

    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_outstanding = r_outstanding;
        w_kill        = r_kill;
        w_skid_valid  = r_skid_valid;
        w_skid_data   = r_skid_data;
        w_instruction = r_instruction;
        w_instr_pc    = r_instr_pc;
        w_instr_valid = r_instr_valid;
        w_halted      = r_halted;
        w_req         = 1'b0;
        w_addr        = 32'h0;

        w_handoff    = r_instr_valid & bus.instr_ready;
        w_rsp        = r_outstanding & bus.imem_rvalid;
        w_prefetch   = (r_state == ST_HOLD) & ~r_outstanding & ~r_skid_valid;
        w_skid_avail = r_skid_valid | w_rsp;
        w_in_flight  = (r_outstanding & ~bus.imem_rvalid) | w_prefetch;
        w_skid_word  = r_skid_valid ? r_skid_data : bus.imem_rdata;

        case (r_state)
            ST_RESET: w_state = ST_FETCH;
            ST_FETCH: begin
                w_req         = 1'b1;
                w_addr        = r_pc;
                w_outstanding = 1'b1;
                w_state       = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_rsp) begin
                    w_outstanding = 1'b0;
                    if (r_kill) begin
                        w_kill  = 1'b0;
                        w_state = ST_FETCH;
                    end else begin
                        w_instruction = bus.imem_rdata;
                        w_instr_pc    = r_pc;
                        w_instr_valid = 1'b1;
                        w_state       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_prefetch) begin
                    w_req         = 1'b1;
                    w_addr        = w_pc4;
                    w_outstanding = 1'b1;
                end
                if (w_rsp) begin
                    w_outstanding = 1'b0;
                    w_skid_valid  = 1'b1;
                    w_skid_data   = bus.imem_rdata;
                end
                if (w_handoff) begin
                    if (bus.is_illegal) begin
                        w_state       = ST_HALT;
                        w_halted      = 1'b1;
                        w_instr_valid = 1'b0;
                        w_outstanding = 1'b0;
                        w_skid_valid  = 1'b0;
                    end else if ((w_next_pc == w_pc4) && w_skid_avail) begin
                        // Sequential hit on the prefetched word: present it with no bubble
                        w_instruction = w_skid_word;
                        w_instr_pc    = w_pc4;
                        w_pc          = w_pc4;
                        w_skid_valid  = 1'b0;
                        w_outstanding = 1'b0;
                    end else if (w_in_flight) begin
                        w_kill        = (w_next_pc != w_pc4);
                        w_pc          = w_next_pc;
                        w_instr_valid = 1'b0;
                        w_state       = ST_WAIT;
                    end else begin
                        w_skid_valid  = 1'b0;
                        w_outstanding = 1'b0;
                        w_pc          = w_next_pc;
                        w_instr_valid = 1'b0;
                        w_state       = ST_FETCH;
                    end
                end
            end
            ST_HALT: w_state = ST_HALT;
            default: w_state = ST_RESET;
        endcase
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = {w_addr[31:2], 2'b00};
    assign bus.instruction = r_instruction;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.halted      = r_halted;

endmodule

`default_nettype wire
